dram_march_bist: RTL and testbench
==================================

Name: dram_march_bist

Overview:
- Built-in self-test controller that sits directly upstream of a 256x1 single-port distributed RAM (RAM256X1S-class primitive).
- Drives the RAM's address, data and write-enable.
- Consumes the RAM's asynchronous read output.
- Runs a three-element march test (W0 ascending; R0/W1 ascending; R1 descending) and reports pass/fail, error count and first failing address for display on board LEDs.

Parameters:
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock; RAM WCLK is driven from the same net.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; a high sample in IDLE begins a test run.
- ram_o  input  1  RAM read data; combinational function of ram_addr.
- ram_addr  output  ADDR_W  RAM address (A).
- ram_d  output  1  RAM write data (D).
- ram_we  output  1  RAM write enable (WE).
- busy  output  1  high while a test run is in progress.
- done  output  1  one-cycle pulse on run completion.
- pass  output  1  result of the last completed run; 1 = no mismatches.
- err_count  output  ERR_W  mismatch count of the current or last run; saturates at all-ones.
- first_fail  output  ADDR_W  address of the first mismatch of the run; 0 if none.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values (all outputs registered):
  - ram_addr = 0, ram_d = 0, ram_we = 0.
  - busy = 0, done = 0, pass = 0.
  - err_count = 0, first_fail = 0.
  - State = IDLE.
- States: IDLE, WR0, RW01, RD1, FIN.
- IDLE:
  - ram_we = 0, busy = 0.
  - On start = 1 at a clock edge:
    - clear err_count, first_fail and the first-fail-seen flag; pass = 0.
    - ram_addr = 0, ram_d = 0, ram_we = 1, busy = 1.
    - go to WR0.
- WR0 (one address per cycle):
  - Write 0 to each address 0..2**ADDR_W-1, ascending.
  - After the cycle that presents the last address: ram_addr = 0, ram_d = 1, ram_we = 1; go to RW01.
- RW01 (one address per cycle, ascending):
  - At each edge, sample ram_o (old contents, before the write lands) and compare with expected 0.
  - The same edge writes 1 to that address.
  - After the last address: ram_addr = 2**ADDR_W-1, ram_we = 0, ram_d = 0; go to RD1.
- RD1 (one address per cycle, descending 2**ADDR_W-1 down to 0):
  - At each edge, sample ram_o and compare with expected 1; no writes.
  - After address 0: go to FIN.
- Mismatch handling:
  - Increment err_count, holding at all-ones once reached.
  - If this is the first mismatch of the run, capture the current ram_addr into first_fail.
- FIN (one cycle):
  - done = 1, pass = (err_count == 0), busy = 0, ram_we = 0.
  - Next state IDLE.
  - done is high only in FIN.
- Held values: pass, err_count and first_fail hold until the next accepted start or rst.
- Run length (one address per cycle, no stalls):
  - busy is high for exactly 3*2**ADDR_W cycles (768 at default).
  - done asserts on the cycle after busy falls.
- start while busy or in FIN: ignored; no restart and no effect on results.
- Back-to-back runs: start held high continuously restarts a run in the IDLE cycle following FIN.
- rst mid-run:
  - ram_we drops immediately (asynchronously); all outputs return to reset values.
  - RAM contents are undefined thereafter; the next run rewrites all of them.
- ram_o: treated as a same-cycle combinational input; not re-registered before comparison.

Test Plan:
- Fault-free behavioural 256x1 RAM model, start pulsed once -> busy high 768 cycles, done pulse 1 cycle later, pass = 1, err_count = 0, first_fail = 0, RAM holds all ones.
- Address 0x5A stuck-at-0 -> RD1 mismatch only; err_count = 1, first_fail = 0x5A, pass = 0.
- Addresses 0x00 and 0xFF stuck-at-1 -> RW01 mismatches at 0x00 then 0xFF; err_count = 2, first_fail = 0x00, pass = 0.
- Whole array stuck-at-0 -> 256 RD1 mismatches; err_count saturates at 0xFF, first_fail = 0xFF (descending), pass = 0.
- start re-pulsed at cycle 300 of a run -> run unaffected; done still at cycle 769, no second run begins.
- rst asserted mid-RW01 at address 0x40 -> ram_we = 0 and busy = 0 without waiting for a clock edge; a subsequent start on a fault-free model yields pass = 1.

Source files
------------

// File: rtl/dram_march_bist_if.sv
// RAM-side bus between the march BIST controller and a 2**ADDR_W x 1
// single-port distributed RAM with asynchronous read.
interface dram_march_bist_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_d;
    logic              ram_we;
    logic              ram_o;

    modport master (
        output ram_addr,
        output ram_d,
        output ram_we,
        input  ram_o
    );

    modport slave (
        input  ram_addr,
        input  ram_d,
        input  ram_we,
        output ram_o
    );
endinterface

// File: rtl/dram_march_bist.sv
// Three-element march BIST (W0 up; R0/W1 up; R1 down) for a 1-bit-wide
// distributed RAM, reporting pass, saturating error count and first failing address.
module dram_march_bist #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    dram_march_bist_if.master  ram,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_fail
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR0  = 3'd1;
    localparam logic [2:0] RW01 = 3'd2;
    localparam logic [2:0] RD1  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0]       state;
    logic             seen;
    logic             chk;
    logic             mis;
    logic             last_up;
    logic             last_dn;
    logic [ERR_W-1:0] err_nxt;

    // RW01 expects the old 0 before its write lands; RD1 expects 1.
    always_comb begin
        chk     = (state == RW01) || (state == RD1);
        mis     = chk && (ram.ram_o != (state == RD1));
        last_up = &ram.ram_addr;
        last_dn = (ram.ram_addr == '0);
        err_nxt = err_count;
        if (mis && !(&err_count))
            err_nxt = err_count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            seen         <= 1'b0;
            ram.ram_addr <= '0;
            ram.ram_d    <= 1'b0;
            ram.ram_we   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            first_fail   <= '0;
        end else begin
            done <= 1'b0;
            if (chk) begin
                err_count <= err_nxt;
                if (mis && !seen) begin
                    seen       <= 1'b1;
                    first_fail <= ram.ram_addr;
                end
            end
            unique case (state)
                IDLE: begin
                    ram.ram_we <= 1'b0;
                    busy       <= 1'b0;
                    if (start) begin
                        err_count    <= '0;
                        first_fail   <= '0;
                        seen         <= 1'b0;
                        pass         <= 1'b0;
                        ram.ram_addr <= '0;
                        ram.ram_d    <= 1'b0;
                        ram.ram_we   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= WR0;
                    end
                end
                WR0: begin
                    ram.ram_addr <= ram.ram_addr + 1'b1;
                    if (last_up) begin
                        ram.ram_d <= 1'b1;
                        state     <= RW01;
                    end
                end
                RW01: begin
                    ram.ram_addr <= ram.ram_addr + 1'b1;
                    if (last_up) begin
                        ram.ram_addr <= '1;
                        ram.ram_we   <= 1'b0;
                        ram.ram_d    <= 1'b0;
                        state        <= RD1;
                    end
                end
                RD1: begin
                    ram.ram_addr <= ram.ram_addr - 1'b1;
                    if (last_dn) begin
                        ram.ram_addr <= '0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        pass         <= (err_nxt == '0);
                        state        <= FIN;
                    end
                end
                FIN: begin
                    ram.ram_we <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_march_bist.sv
// Directed bench for dram_march_bist with a behavioural 256x1 RAM
// that supports per-address stuck-at-0 / stuck-at-1 faults.
module tb_dram_march_bist;
    localparam int AW = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_fail;

    dram_march_bist_if #(.ADDR_W(AW)) rif ();

    dram_march_bist #(.ADDR_W(AW), .ERR_W(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ram        (rif),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;

    logic mem [256];
    logic s0  [256];
    logic s1  [256];

    assign rif.ram_o = s0[rif.ram_addr] ? 1'b0 :
                       (s1[rif.ram_addr] ? 1'b1 : mem[rif.ram_addr]);

    always @(posedge clk)
        if (rif.ram_we) mem[rif.ram_addr] <= rif.ram_d;

    int tests = 0;
    int fails = 0;
    int bcnt, dcyc, dcnt;

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin
            s0[i] = 1'b0;
            s1[i] = 1'b0;
        end
    endtask

    // Pulse start once, then observe 900 cycles at negedges.
    // Cycle 1 is the first cycle after the accepting edge.
    task automatic do_run(input int restart_at);
        bcnt = 0; dcyc = 0; dcnt = 0;
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 900; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (restart_at != 0 && n == restart_at) start = 1'b1;
            if (restart_at != 0 && n == restart_at + 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                if (dcyc == 0) dcyc = n;
                dcnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if ({rif.ram_we, rif.ram_d, busy, done, pass} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000",
                     {rif.ram_we, rif.ram_d, busy, done, pass});
        end
        tests++;
        if (rif.ram_addr !== 8'h00) begin
            fails++;
            $display("FAIL reset_addr: got %h want 00", rif.ram_addr);
        end
        tests++;
        if ({err_count, first_fail} !== 16'h0) begin
            fails++;
            $display("FAIL reset_stats: got %h want 0000",
                     {err_count, first_fail});
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rif.ram_we !== 1'b0) begin
            fails++;
            $display("FAIL idle_quiet: busy %b we %b want 0 0", busy, rif.ram_we);
        end
    endtask

    task automatic test_fault_free();
        int bad;
        clear_faults();
        do_run(0);
        tests++;
        if (bcnt !== 768) begin
            fails++;
            $display("FAIL ff_busy_len: got %0d want 768", bcnt);
        end
        tests++;
        if (dcyc !== 769 || dcnt !== 1) begin
            fails++;
            $display("FAIL ff_done: cycle %0d count %0d want 769 1", dcyc, dcnt);
        end
        tests++;
        if (pass !== 1'b1 || err_count !== 8'h00 || first_fail !== 8'h00) begin
            fails++;
            $display("FAIL ff_result: pass %b err %h ff %h want 1 00 00",
                     pass, err_count, first_fail);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 1'b1) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL ff_ram_ones: got %0d non-one cells want 0", bad);
        end
    endtask

    task automatic test_stuck0_5a();
        clear_faults();
        s0[8'h5A] = 1'b1;
        do_run(0);
        tests++;
        if (pass !== 1'b0 || err_count !== 8'd1 || first_fail !== 8'h5A) begin
            fails++;
            $display("FAIL sa0_5a: pass %b err %h ff %h want 0 01 5a",
                     pass, err_count, first_fail);
        end
    endtask

    task automatic test_stuck1_ends();
        clear_faults();
        s1[0]   = 1'b1;
        s1[255] = 1'b1;
        do_run(0);
        tests++;
        if (pass !== 1'b0 || err_count !== 8'd2 || first_fail !== 8'h00) begin
            fails++;
            $display("FAIL sa1_ends: pass %b err %h ff %h want 0 02 00",
                     pass, err_count, first_fail);
        end
    endtask

    task automatic test_all_stuck0();
        clear_faults();
        for (int i = 0; i < 256; i++) s0[i] = 1'b1;
        do_run(0);
        tests++;
        if (pass !== 1'b0 || err_count !== 8'hFF || first_fail !== 8'hFF) begin
            fails++;
            $display("FAIL sa0_all: pass %b err %h ff %h want 0 ff ff",
                     pass, err_count, first_fail);
        end
        tests++;
        if (dcyc !== 769) begin
            fails++;
            $display("FAIL sa0_all_done: got %0d want 769", dcyc);
        end
    endtask

    task automatic test_restart_ignored();
        clear_faults();
        do_run(300);
        tests++;
        if (bcnt !== 768 || dcyc !== 769 || dcnt !== 1) begin
            fails++;
            $display("FAIL restart: busy %0d done@%0d n %0d want 768 769 1",
                     bcnt, dcyc, dcnt);
        end
        tests++;
        if (pass !== 1'b1 || err_count !== 8'h00) begin
            fails++;
            $display("FAIL restart_result: pass %b err %h want 1 00", pass, err_count);
        end
    endtask

    task automatic test_rst_midrun();
        int n;
        clear_faults();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(rif.ram_addr == 8'h40 && rif.ram_d && rif.ram_we) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL rst_mid_reach: got timeout want RW01 @40");
        end
        rst = 1'b1;
        #1;
        tests++;
        if (rif.ram_we !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: we %b busy %b want 0 0", rif.ram_we, busy);
        end
        @(negedge clk) rst = 1'b0;
        do_run(0);
        tests++;
        if (pass !== 1'b1 || err_count !== 8'h00 || dcyc !== 769) begin
            fails++;
            $display("FAIL rst_rerun: pass %b err %h done@%0d want 1 00 769",
                     pass, err_count, dcyc);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_faults();
        @(negedge clk) start = 1'b1;
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 769) begin
            fails++;
            $display("FAIL b2b_first_done: got %0d want 769", n);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap: busy %b done %b want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_restart: busy %b want 1", busy);
        end
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 768 || pass !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: cycles %0d pass %b want 768 1", n, pass);
        end
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_fault_free();
        test_stuck0_5a();
        test_stuck1_ends();
        test_all_stuck0();
        test_restart_ignored();
        test_rst_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
